// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the truth-table checker: FSM encoding and the default golden table.
package truth_table_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } tt_state_e;

   // op = (~x & z) | y over {x,y,z}
   localparam logic [7:0] TT_SAMPLE_CIRCUIT = 8'hCE;

   localparam int SETTLE_W = 4;

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// Settle-interval counter: clear has priority over enable; term flags the last hold cycle.
module settle_timer
   import truth_table_checker_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic term
);

   logic [SETTLE_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)     cnt_d = '0;
      else if (en) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign term = (cnt_q == SETTLE_W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive stimulus/response checker: walks every input vector, samples the DUT after a
// settle interval and scores it against a golden truth table.
module truth_table_checker
   import truth_table_checker_pkg::*;
#(
   parameter int                      N_IN   = 3,
   parameter int                      SETTLE = 1,
   parameter logic [(1<<N_IN)-1:0]    EXPECT = TT_SAMPLE_CIRCUIT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [N_IN-1:0] dut_in,
   input  logic            dut_op,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic [N_IN-1:0] first_fail
);

   localparam logic [N_IN-1:0] IDX_LAST = '1;

   tt_state_e       state_q, state_d;
   logic [N_IN-1:0] idx_q, idx_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic [N_IN:0]   err_q, err_d;
   logic [N_IN-1:0] ff_q, ff_d;
   logic            tmr_clr, tmr_en, tmr_term;
   logic            mismatch;

   settle_timer #(.SETTLE(SETTLE)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tmr_clr),
      .en    (tmr_en),
      .term  (tmr_term)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;
      err_d    = err_q;
      ff_d     = ff_q;
      tmr_clr  = 1'b0;
      tmr_en   = 1'b0;
      mismatch = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               idx_d   = '0;
               err_d   = '0;
               ff_d    = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
               tmr_clr = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            tmr_en = 1'b1;
            if (tmr_term) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            // dut_op is only looked at here, so an X outside CHECK never reaches the scoreboard
            mismatch = (dut_op != EXPECT[idx_q]);
            if (mismatch) begin
               err_d = err_q + 1'b1;
               if (err_q == '0) ff_d = idx_q;
            end
            if (idx_q == IDX_LAST) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               tmr_clr = 1'b1;
               state_d = ST_WAIT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         ff_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
      end
   end

   // idx is itself a flop, so driving it straight out keeps dut_in registered
   assign dut_in     = idx_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign first_fail = ff_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: golden, faulty and restart/reset scenarios.
module tb_truth_table_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] dut_in;
   logic       dut_op;
   logic       busy, done, pass;
   logic [3:0] err_count;
   logic [2:0] first_fail;

   logic       start3 = 1'b0;
   logic [2:0] dut_in3;
   logic       dut_op3;
   logic       busy3, done3, pass3;
   logic [3:0] err_count3;
   logic [2:0] first_fail3;

   int mode = 0;  // 0 correct, 1 stuck-at-0, 2 inverted
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   function automatic logic golden(input logic [2:0] v);
      return (~v[2] & v[0]) | v[1];
   endfunction

   always_comb begin
      case (mode)
         1:       dut_op = 1'b0;
         2:       dut_op = ~golden(dut_in);
         default: dut_op = golden(dut_in);
      endcase
   end
   assign dut_op3 = golden(dut_in3);

   truth_table_checker u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_op(dut_op),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_fail(first_fail)
   );

   truth_table_checker #(.SETTLE(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .dut_in(dut_in3), .dut_op(dut_op3),
      .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3), .first_fail(first_fail3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 64) begin
         tick();
         n++;
      end
      n_checks++;
      if (done !== 1'b1) begin
         $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, n);
         n_fail++;
      end
   endtask

   task automatic test_reset();
      tick(); tick();
      n_checks++;
      if ({busy, done, pass, err_count, first_fail, dut_in} !== 13'd0) begin
         $display("FAIL reset_outputs: got %b, required all zero",
                  {busy, done, pass, err_count, first_fail, dut_in});
         n_fail++;
      end
      n_checks++;
      if ({busy3, done3, pass3, err_count3, first_fail3, dut_in3} !== 13'd0) begin
         $display("FAIL reset_outputs_s3: got %b, required all zero",
                  {busy3, done3, pass3, err_count3, first_fail3, dut_in3});
         n_fail++;
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_correct_run();
      mode = 0;
      pulse_start();
      for (int k = 0; k < 16; k++) begin
         n_checks++;
         if (busy !== 1'b1 || done !== 1'b0 || dut_in !== 3'(k / 2)) begin
            $display("FAIL run_step k=%0d: busy=%b done=%b dut_in=%0d, required 1 0 %0d",
                     k, busy, done, dut_in, k / 2);
            n_fail++;
         end
         tick();
      end
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || err_count !== 4'd0 || first_fail !== 3'd0) begin
         $display("FAIL run_result: done=%b busy=%b pass=%b err=%0d ff=%0d, required 1 0 1 0 0",
                  done, busy, pass, err_count, first_fail);
         n_fail++;
      end
   endtask

   task automatic test_stuck0();
      int n;
      mode = 1;
      pulse_start();
      wait_done(n);
      n_checks++;
      if (n !== 16) begin
         $display("FAIL stuck0_latency: %0d cycles, required 16", n);
         n_fail++;
      end
      n_checks++;
      if (err_count !== 4'd5 || first_fail !== 3'd1 || pass !== 1'b0) begin
         $display("FAIL stuck0_result: err=%0d ff=%0d pass=%b, required 5 1 0",
                  err_count, first_fail, pass);
         n_fail++;
      end
   endtask

   task automatic test_inverted();
      int n;
      mode = 2;
      pulse_start();
      wait_done(n);
      n_checks++;
      if (err_count !== 4'd8 || first_fail !== 3'd0 || pass !== 1'b0) begin
         $display("FAIL inverted_result: err=%0d ff=%0d pass=%b, required 8 0 0",
                  err_count, first_fail, pass);
         n_fail++;
      end
      mode = 0;
      pulse_start();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b1 || err_count !== 4'd0 || first_fail !== 3'd0 || pass !== 1'b0) begin
         $display("FAIL restart_clear: done=%b busy=%b err=%0d ff=%0d pass=%b, required 0 1 0 0 0",
                  done, busy, err_count, first_fail, pass);
         n_fail++;
      end
      wait_done(n);
      n_checks++;
      if (pass !== 1'b1 || err_count !== 4'd0) begin
         $display("FAIL restart_result: pass=%b err=%0d, required 1 0", pass, err_count);
         n_fail++;
      end
   endtask

   task automatic test_start_ignored();
      int n;
      mode = 0;
      pulse_start();
      for (int k = 1; k <= 16; k++) begin
         start = (k == 5 || k == 9);
         tick();
         start = 1'b0;
         n_checks++;
         if (k < 16) begin
            if (busy !== 1'b1 || done !== 1'b0 || dut_in !== 3'(k / 2)) begin
               $display("FAIL ignore_step k=%0d: busy=%b done=%b dut_in=%0d, required 1 0 %0d",
                        k, busy, done, dut_in, k / 2);
               n_fail++;
            end
         end else if (done !== 1'b1 || pass !== 1'b1) begin
            $display("FAIL ignore_done: done=%b pass=%b, required 1 1", done, pass);
            n_fail++;
         end
      end
      pulse_start();
      n_checks++;
      if (done !== 1'b0 || pass !== 1'b0 || busy !== 1'b1 || dut_in !== 3'd0) begin
         $display("FAIL done_restart: done=%b pass=%b busy=%b dut_in=%0d, required 0 0 1 0",
                  done, pass, busy, dut_in);
         n_fail++;
      end
      wait_done(n);
      n_checks++;
      if (n !== 16 || pass !== 1'b1 || err_count !== 4'd0) begin
         $display("FAIL second_run: cycles=%0d pass=%b err=%0d, required 16 1 0", n, pass, err_count);
         n_fail++;
      end
   endtask

   task automatic test_reset_mid_run();
      int n;
      mode = 1;
      pulse_start();
      n = 0;
      while (dut_in !== 3'd3 && n < 20) begin
         tick();
         n++;
      end
      n_checks++;
      if (dut_in !== 3'd3) begin
         $display("FAIL reach_vec3: dut_in=%0d, required 3", dut_in);
         n_fail++;
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, pass, err_count, first_fail, dut_in} !== 13'd0) begin
         $display("FAIL async_reset: got %b, required all zero",
                  {busy, done, pass, err_count, first_fail, dut_in});
         n_fail++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick(); tick();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || dut_in !== 3'd0) begin
         $display("FAIL post_reset_idle: busy=%b done=%b dut_in=%0d, required 0 0 0", busy, done, dut_in);
         n_fail++;
      end
      mode = 0;
      pulse_start();
      wait_done(n);
      n_checks++;
      if (n !== 16 || pass !== 1'b1 || err_count !== 4'd0 || first_fail !== 3'd0) begin
         $display("FAIL post_reset_run: cycles=%0d pass=%b err=%0d ff=%0d, required 16 1 0 0",
                  n, pass, err_count, first_fail);
         n_fail++;
      end
   endtask

   task automatic test_settle3();
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      for (int k = 0; k < 32; k++) begin
         n_checks++;
         if (busy3 !== 1'b1 || done3 !== 1'b0 || dut_in3 !== 3'(k / 4)) begin
            $display("FAIL settle3_step k=%0d: busy=%b done=%b dut_in=%0d, required 1 0 %0d",
                     k, busy3, done3, dut_in3, k / 4);
            n_fail++;
         end
         tick();
      end
      n_checks++;
      if (done3 !== 1'b1 || busy3 !== 1'b0 || pass3 !== 1'b1 || err_count3 !== 4'd0) begin
         $display("FAIL settle3_result: done=%b busy=%b pass=%b err=%0d, required 1 0 1 0",
                  done3, busy3, pass3, err_count3);
         n_fail++;
      end
   endtask

   initial begin
      test_reset();
      test_correct_run();
      test_stuck0();
      test_inverted();
      test_start_ignored();
      test_reset_mid_run();
      test_settle3();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Self-checking stimulus/response engine for small combinational DUTs: the sequential counterpart of a hand-written exhaustive testbench.
- On `start`, walks all 2^N_IN input vectors, drives them to the DUT, waits a settle interval and samples the DUT output. Compares each sample against a parameterised golden truth table and reports pass/fail, error count and first failing vector.
- Sits beside the DUT in lab-day benches and FPGA self-test wrappers.

Parameters:
- N_IN, 3, number of DUT inputs; vector index idx is N_IN bits, MSB drives the first DUT input (x).
- SETTLE, 1, cycles each vector is held before sampling; legal range 1..15.
- EXPECT, 8'hCE, golden truth table, 2^N_IN bits; bit idx = expected output for vector idx. The default encodes op = (~x & z) | y.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  single-cycle pulse; begins a run when not busy
- dut_in  output  N_IN  registered vector to DUT; {x,y,z} for N_IN=3
- dut_op  input  1  DUT response, combinationally derived from dut_in
- busy  output  1  high from start acceptance until done
- done  output  1  high (level) once a run completes; held until next accepted start
- pass  output  1  done && err_count==0
- err_count  output  N_IN+1  number of mismatching vectors in last run
- first_fail  output  N_IN  index of first mismatch; valid when err_count!=0, else 0

Behaviour:
- Reset (async assert, sync release): state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, settle counter=0.
- States: IDLE, WAIT, CHECK, DONE.
- IDLE/DONE + start=1: idx<=0, dut_in<=0, err_count<=0, first_fail<=0, done<=0, pass<=0, busy<=1, settle cnt<=0, go WAIT.
- WAIT: dut_in stable; cnt increments each cycle; when cnt==SETTLE-1 go CHECK.
- CHECK (one cycle):
  - sample dut_op; mismatch if dut_op != EXPECT[idx].
  - On mismatch: err_count+1; if err_count==0 before the increment, first_fail<=idx.
  - If idx==2^N_IN-1: go DONE, busy<=0, done<=1, pass<=(final err_count==0).
  - Else: idx+1, dut_in<=idx+1, cnt<=0, go WAIT.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - A full run takes 2^N_IN*(SETTLE+1) cycles from the start edge to the done-rising edge; 16 cycles for the defaults.
- start while busy (WAIT/CHECK): ignored; no restart, no state change.
- start in DONE: clears results and restarts exactly as from IDLE.
- err_count is N_IN+1 bits, so the maximum 2^N_IN never overflows; no saturation needed.
- idx does not wrap: the terminal vector always exits to DONE.
- dut_op may be X in the cycle after reset release. It is never sampled outside CHECK.
- Reset mid-run: immediate return to all reset values; partial results are discarded.
- All outputs are registered; no combinational path from dut_op to any output.

Decomposition:
- Shared include `tt_check_defs`:
  - state encodings ST_IDLE=2'd0, ST_WAIT=2'd1, ST_CHECK=2'd2, ST_DONE=2'd3.
  - default golden constant TT_SAMPLE_CIRCUIT=8'hCE.
- One natural sub-module: `settle_timer` (4-bit counter with clear/enable and terminal flag cnt==SETTLE-1), instantiated once.
- FSM, idx register and scoreboard stay in the top module.

Test Plan:
1. Defaults with correct DUT (op=(~x&z)|y), start pulse at cycle 2 -> busy high for 16 cycles; dut_in steps 0..7 every 2 cycles; done=1, pass=1, err_count=0, first_fail=0.
2. DUT stuck-at-0 -> mismatches at idx 1,2,3,6,7 -> err_count=5, first_fail=1, pass=0.
3. DUT output inverted -> err_count=8, first_fail=0, pass=0.
4. start re-pulsed at cycles 5 and 9 during a run -> ignored; done still rises 16 cycles after the first start. start pulsed again in DONE -> results clear next cycle and a second identical run completes.
5. rst_n pulled low while dut_in=3 -> all outputs 0 asynchronously, state IDLE. After release, start gives a full clean run with pass=1.
6. SETTLE=3 with correct DUT -> each vector held 4 cycles, done after 32 cycles, pass=1.
